// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI burst arbiter: FSM encoding, default timing
// constants and the index-width helper used to size requester indices.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } arb_state_e;

   localparam int DEF_N_REQ          = 2;
   localparam int DEF_HOLD_CYCLES    = 4095;
   localparam int DEF_TIMEOUT_CYCLES = 65535;

   // Bits needed to index n requesters; never less than one.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_burst_arbiter_if.sv
// Requester and SPI-engine signals of the burst arbiter. The arbiter uses the
// slave modport; requesters/engine (or a bench) drive the master side.
interface spi_burst_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   byte_valid;
   logic [N_REQ-1:0]   byte_last;
   logic [8*N_REQ-1:0] byte_data;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   byte_ack;
   logic [N_REQ-1:0]   done;
   logic [7:0]         send_data;
   logic               begin_transmission;
   logic               end_transmission;
   logic               slave_select;
   logic               timeout_err;

   modport slave (
      input  req, byte_valid, byte_last, byte_data, end_transmission,
      output grant, byte_ack, done, send_data, begin_transmission, slave_select, timeout_err
   );

   modport master (
      output req, byte_valid, byte_last, byte_data, end_transmission,
      input  grant, byte_ack, done, send_data, begin_transmission, slave_select, timeout_err
   );

endinterface

// File: rtl/spi_burst_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping from N_REQ-1 to 0. Returns one-hot, index and an any-request flag.
module rr_pick
   import spi_arb_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   localparam int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [IW-1:0]    idx,
   output logic             any
);

   int pos;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos    = 0;
      // Walk from the farthest offset down so the nearest hit is written last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = (int'(ptr) + k) % N_REQ;
         if (req[pos]) begin
            onehot      = '0;
            onehot[pos] = 1'b1;
            idx         = IW'(pos);
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Round-robin burst arbiter sharing one SPI byte engine among N_REQ requesters.
// Optional watchdog on end_transmission enabled by macro SPI_ARB_TIMEOUT_EN.
module spi_burst_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ          = DEF_N_REQ,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   spi_burst_arbiter_if.slave bus
);

   localparam int            IW        = idx_width(N_REQ);
   localparam int            HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   if (N_REQ < 2 || N_REQ > 8 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("spi_burst_arbiter: illegal parameter set");
   end

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d, byte_ack_q, byte_ack_d, done_q, done_d;
   logic [IW-1:0]    idx_q, idx_d, rr_q, rr_d, rr_next;
   logic [7:0]       send_data_q, send_data_d;
   logic             last_q, last_d, begin_q, begin_d, ss_q, ss_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic             hold_done, tmo_hit;
   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req    (bus.req),
      .ptr    (rr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign hold_done = (hold_cnt_q == HOLD_LAST);
   assign rr_next   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          timeout_q, timeout_d;

   assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = (state_q == WAIT) ? tmo_cnt_q + TW'(1) : '0;
      timeout_d = (state_q == WAIT) && !bus.end_transmission && tmo_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout_err = timeout_q;
`else
   assign tmo_hit         = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // NOTE: reset is synchronous, so it lives inside the clocked branch.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (pick_any)                 state_d = FETCH;
         FETCH: if (bus.byte_valid[idx_q])    state_d = WAIT;
         WAIT:  if (bus.end_transmission)     state_d = last_q ? HOLD : FETCH;
                else if (tmo_hit)             state_d = IDLE;
         HOLD:  if (hold_done)                state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d     = grant_q;
      idx_d       = idx_q;
      rr_d        = rr_q;
      send_data_d = send_data_q;
      last_d      = last_q;
      ss_d        = ss_q;
      begin_d     = 1'b0;
      byte_ack_d  = '0;
      done_d      = '0;
      hold_cnt_d  = (state_q == HOLD) ? hold_cnt_q + HW'(1) : '0;
      unique case (state_q)
         IDLE: if (pick_any) begin
            grant_d = pick_onehot;
            idx_d   = pick_idx;
            ss_d    = 1'b0;
         end
         FETCH: if (bus.byte_valid[idx_q]) begin
            send_data_d = bus.byte_data[8*idx_q +: 8];
            last_d      = bus.byte_last[idx_q];
            begin_d     = 1'b1;
         end
         WAIT: if (bus.end_transmission) begin
            byte_ack_d[idx_q] = 1'b1;
         end else if (tmo_hit) begin
            // Watchdog abort: release the bus silently and move past the owner.
            ss_d    = 1'b1;
            grant_d = '0;
            rr_d    = rr_next;
         end
         HOLD: if (hold_done) begin
            ss_d          = 1'b1;
            grant_d       = '0;
            done_d[idx_q] = 1'b1;
            rr_d          = rr_next;
         end
         default: ;
      endcase
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q     <= '0;
         idx_q       <= '0;
         rr_q        <= '0;
         send_data_q <= 8'h00;
         last_q      <= 1'b0;
         ss_q        <= 1'b1;
         begin_q     <= 1'b0;
         byte_ack_q  <= '0;
         done_q      <= '0;
         hold_cnt_q  <= '0;
      end else begin
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         rr_q        <= rr_d;
         send_data_q <= send_data_d;
         last_q      <= last_d;
         ss_q        <= ss_d;
         begin_q     <= begin_d;
         byte_ack_q  <= byte_ack_d;
         done_q      <= done_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.grant              = grant_q;
   assign bus.byte_ack           = byte_ack_q;
   assign bus.done               = done_q;
   assign bus.send_data          = send_data_q;
   assign bus.begin_transmission = begin_q;
   assign bus.slave_select       = ss_q;

endmodule
